// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// opcode/funct constants and the decoder output bundle.
// Optional feature macro used by this slice: CTRL_ILLEGAL_TRAP_EN.
package ctrl_pkg;

  // FSM state encodings (0-4), kept as plain constants for legacy tools.
  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALT      = 3'd4;

  // Opcode field values (instruction bits 31:26).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LI    = 6'b000001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Funct values that take ALU operand B from the shift amount.
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // Decoder result: control bits plus instruction class flags.
  typedef struct packed {
    logic alu_op;
    logic alu_src;
    logic wb_src;
    logic legal;
    logic halt;
  } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the datapath and the multicycle controller.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN adds the sticky Illegal flag.
//
// There is no valid/ready handshake here: the controller samples Opcode and
// Funct during its DECODE cycle, and PC_en is the single-cycle strobe that
// tells the datapath to fetch the next instruction. State is a debug view of
// the FSM encoding.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Opcode;
  logic [5:0]       Funct;
  logic             Reg_write;
  logic             ALU_op;
  logic             ALU_src;
  logic             Writeback_src;
  logic             PC_en;
  logic             Halted;
  logic [CNT_W-1:0] Retired;
  logic [2:0]       State;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic             Illegal;
`endif

  modport master (
    output Opcode, Funct,
    input  Reg_write, ALU_op, ALU_src, Writeback_src, PC_en, Halted, Retired,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  Illegal,
`endif
    input  State
  );

  modport slave (
    input  Opcode, Funct,
    output Reg_write, ALU_op, ALU_src, Writeback_src, PC_en, Halted, Retired,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output Illegal,
`endif
    output State
  );
endinterface

// File: rtl/multicycle_control_decoder.sv
// Combinational instruction decoder: {Opcode, Funct} -> control bits and
// legal/halt classification. Unknown opcodes decode to all zeros.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  // Table lookup on the opcode; only R-type looks at Funct.
  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.legal   = 1'b1;
        o_dec.alu_op  = 1'b1;
        o_dec.alu_src = (i_funct == FN_SLL) || (i_funct == FN_SRL);
        o_dec.wb_src  = 1'b0;
      end
      OP_LI: begin
        o_dec.legal  = 1'b1;
        o_dec.wb_src = 1'b1;
      end
      OP_HALT: begin
        o_dec.legal = 1'b1;
        o_dec.halt  = 1'b1;
      end
      default: o_dec = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle controller: FETCH -> DECODE -> EXECUTE -> WRITEBACK, four cycles
// per instruction, with an absorbing HALT state and a saturating counter of
// retired (written-back) instructions.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- illegal opcodes trap to HALT
// and set a sticky Illegal flag; without it they run as a NOP.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  multicycle_control_if.slave  bus
);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [5:0]       r_opcode;
  logic [5:0]       r_funct;
  logic [5:0]       w_dec_opcode;
  logic [5:0]       w_dec_funct;
  dec_t             w_dec;
  logic [CNT_W-1:0] r_retired;
  logic             w_in_decode;
  logic             w_in_exec_wb;
  logic             w_in_wb;
  logic             w_reg_write;

  assign w_in_decode  = (r_state == ST_DECODE);
  assign w_in_wb      = (r_state == ST_WRITEBACK);
  assign w_in_exec_wb = (r_state == ST_EXECUTE) || w_in_wb;

  // During DECODE the live inputs are decoded (to pick the next state); after
  // that only the registered copy is used, so input changes cannot disturb
  // the instruction in flight.
  assign w_dec_opcode = w_in_decode ? bus.Opcode : r_opcode;
  assign w_dec_funct  = w_in_decode ? bus.Funct  : r_funct;

  ctrl_decoder u_decoder (
    .i_opcode (w_dec_opcode),
    .i_funct  (w_dec_funct),
    .o_dec    (w_dec)
  );

  // Next-state selection; HALT only leaves through Reset.
  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH:     w_next_state = ST_DECODE;
      ST_DECODE: begin
        if (w_dec.halt) begin
          w_next_state = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
        end else if (!w_dec.legal) begin
          w_next_state = ST_HALT;
`endif
        end else begin
          w_next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE:   w_next_state = ST_WRITEBACK;
      ST_WRITEBACK: w_next_state = ST_FETCH;
      ST_HALT:      w_next_state = ST_HALT;
      default:      w_next_state = ST_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // Capture the instruction fields once, in DECODE.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_opcode <= '0;
      r_funct  <= '0;
    end else if (w_in_decode) begin
      r_opcode <= bus.Opcode;
      r_funct  <= bus.Funct;
    end
  end

  // Only a legal, non-halt instruction writes; illegal NOPs fall through here.
  assign w_reg_write = w_in_wb && w_dec.legal && !w_dec.halt;

  // Retired count bumps on the edge leaving WRITEBACK and sticks at all-ones.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_retired <= '0;
    end else if (w_reg_write && (r_retired != '1)) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky flag raised when an unknown opcode is seen in DECODE.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                             r_illegal <= 1'b0;
    else if (w_in_decode && !w_dec.legal)  r_illegal <= 1'b1;
  end

  assign bus.Illegal = r_illegal;
`endif

  // Control outputs are gated by state so FETCH/DECODE/HALT drive zeros.
  assign bus.ALU_op        = w_in_exec_wb && w_dec.alu_op;
  assign bus.ALU_src       = w_in_exec_wb && w_dec.alu_src;
  assign bus.Writeback_src = w_in_exec_wb && w_dec.wb_src;
  assign bus.Reg_write     = w_reg_write;
  assign bus.PC_en         = w_in_wb;
  assign bus.Halted        = (r_state == ST_HALT);
  assign bus.Retired       = r_retired;
  assign bus.State         = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (CNT_W=16 and CNT_W=4) share the
// same stimulus; expectations come from an instruction-level reference model.
module tb_multicycle_control;

  logic clk;
  logic rst;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int          model_retired;
  logic        model_illegal;
  logic [15:0] exp_q[$];

  multicycle_control_if #(.CNT_W(16)) bus16 ();
  multicycle_control_if #(.CNT_W(4))  bus4 ();

  multicycle_control #(.CNT_W(16)) dut16 (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus16.slave)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus4.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, input logic [5:0] fn);
    bus16.Opcode = op;
    bus16.Funct  = fn;
    bus4.Opcode  = op;
    bus4.Funct   = fn;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp_ctl = {Reg_write, ALU_op, ALU_src, Writeback_src, PC_en, Halted, State[2:0]}
  task automatic check_all(input string tag, input logic [8:0] exp_ctl);
    int sat4;
    sat4 = (model_retired > 15) ? 15 : model_retired;
    chk({tag, "_ctl16"}, {23'd0, bus16.Reg_write, bus16.ALU_op, bus16.ALU_src,
        bus16.Writeback_src, bus16.PC_en, bus16.Halted, bus16.State}, {23'd0, exp_ctl});
    chk({tag, "_ctl4"}, {23'd0, bus4.Reg_write, bus4.ALU_op, bus4.ALU_src,
        bus4.Writeback_src, bus4.PC_en, bus4.Halted, bus4.State}, {23'd0, exp_ctl});
    chk({tag, "_ret16"}, 32'(bus16.Retired), 32'(model_retired));
    chk({tag, "_ret4"}, 32'(bus4.Retired), 32'(sat4));
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk({tag, "_illegal"}, {31'd0, bus16.Illegal}, {31'd0, model_illegal});
`endif
  endtask

  // Instruction classes straight from the opcode/funct rules.
  function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                   output bit writes, output bit stops,
                                   output bit illegal, output bit aop,
                                   output bit asrc, output bit wbs);
    bit is_halt;
    is_halt = (op == 6'h3F);
    writes  = (op == 6'h00) || (op == 6'h01);
    illegal = !(writes || is_halt);
    aop     = (op == 6'h00);
    asrc    = (op == 6'h00) && ((fn == 6'h00) || (fn == 6'h02));
    wbs     = (op == 6'h01);
`ifdef CTRL_ILLEGAL_TRAP_EN
    stops   = is_halt || illegal;
`else
    stops   = is_halt;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    #2;
    model_retired = 0;
    model_illegal = 1'b0;
    exp_q.delete();
    check_all("reset", {6'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Runs one instruction from FETCH; returns halted=1 if it ended in HALT.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit scramble, input bit reset_in_wb,
                           output bit halted);
    bit writes, stops, illegal, aop, asrc, wbs;
    classify(op, fn, writes, stops, illegal, aop, asrc, wbs);
    halted = 1'b0;
    drive(op, fn);
    #1;
    check_all("fetch", {6'b0, 3'd0});
    @(posedge clk); #1;
    check_all("decode", {6'b0, 3'd1});
    if (stops) begin
      @(posedge clk); #1;
      if (illegal) model_illegal = 1'b1;
      check_all("halt", {5'b0, 1'b1, 3'd4});
      for (int i = 0; i < 3; i++) begin
        drive(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        @(posedge clk); #1;
        check_all("halt_hold", {5'b0, 1'b1, 3'd4});
      end
      halted = 1'b1;
      return;
    end
    @(posedge clk); #1;
    if (scramble) drive(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    #1;
    check_all("execute", {1'b0, aop, asrc, wbs, 1'b0, 1'b0, 3'd2});
    @(posedge clk); #1;
    check_all("writeback", {writes, aop, asrc, wbs, 1'b1, 1'b0, 3'd3});
    if (reset_in_wb) begin
      rst = 1'b1;
      #1;
      model_retired = 0;
      exp_q.delete();
      check_all("wb_reset", {6'b0, 3'd0});
      @(negedge clk);
      rst = 1'b0;
      #1;
      return;
    end
    if (writes) model_retired++;
    exp_q.push_back(16'(model_retired));
    @(posedge clk); #1;
    check_all("retire", {6'b0, 3'd0});
    chk("retired_sb", 32'(bus16.Retired), 32'(exp_q.pop_front()));
  endtask

  // Random instruction mix, including sll/srl, LI, illegal and halt.
  task automatic pick_random(input bit legal_only, output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = legal_only ? $urandom_range(0, 7) : $urandom_range(0, 9);
    fn = 6'($urandom_range(0, 63));
    case (k)
      0, 1, 2, 3: op = 6'h00;
      4: begin op = 6'h00; fn = 6'h00; end
      5: begin op = 6'h00; fn = 6'h02; end
      6, 7: op = 6'h01;
      8: op = 6'($urandom_range(2, 62));
      default: op = 6'h3F;
    endcase
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    bit h;
    rst = 1'b0;
    drive(6'h00, 6'h00);
    #1;
    do_reset();

    // R-type add, srl, sll; LI with inputs scrambled during EXECUTE.
    run_instr(6'h00, 6'h20, 1'b0, 1'b0, h);
    run_instr(6'h00, 6'h02, 1'b0, 1'b0, h);
    run_instr(6'h00, 6'h00, 1'b1, 1'b0, h);
    run_instr(6'h01, 6'h15, 1'b1, 1'b0, h);

    // Illegal opcode: trap or NOP depending on build.
    run_instr(6'h2A, 6'h00, 1'b0, 1'b0, h);
    if (h) do_reset();
    run_instr(6'h00, 6'h22, 1'b0, 1'b0, h);

    // Halt then reset back to FETCH with Retired cleared.
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, h);
    do_reset();

    // Random mix.
    for (int i = 0; i < 24; i++) begin
      pick_random(1'b0, op, fn);
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'b0, h);
      if (h) do_reset();
    end

    // Saturation: 17 legal instructions; CNT_W=4 instance sticks at 4'hF.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pick_random(1'b1, op, fn);
      run_instr(op, fn, 1'b0, 1'b0, h);
    end
    chk("sat_ret4", 32'(bus4.Retired), 32'h0000000F);
    chk("sat_ret16", 32'(bus16.Retired), 32'd17);

    // Reset during WRITEBACK suppresses that write and count.
    run_instr(6'h00, 6'h20, 1'b0, 1'b1, h);
    run_instr(6'h01, 6'h00, 1'b0, 1'b0, h);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
